// File: rtl/uart_rx_os4.sv
// 4x-oversampled UART receiver (LSB first, 1 start, optional parity, 1 stop).
// Flags are registered one clk after the stop sample; no backpressure, so consume each valid pulse on sight.
module uart_rx_os4 #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam logic       PAR_EN   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_meta, rs;
  logic [1:0]           phase, phase_nxt;
  logic [2:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] dout_nxt;
  logic                 perr, perr_nxt;
  logic                 armed, armed_nxt;
  logic                 valid_nxt, frame_err_nxt, parity_err_nxt;
  logic                 sample;

  // Sample point sits two ticks after start detection, i.e. mid-bit at 4x.
  assign sample = tick && (phase == 2'd1);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rs      <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= 2'd0;
      bit_idx    <= 3'd0;
      shreg      <= '0;
      dout       <= '0;
      perr       <= 1'b0;
      armed      <= 1'b1;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      dout       <= dout_nxt;
      perr       <= perr_nxt;
      armed      <= armed_nxt;
      valid      <= valid_nxt;
      frame_err  <= frame_err_nxt;
      parity_err <= parity_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    phase_nxt      = phase;
    bit_idx_nxt    = bit_idx;
    shreg_nxt      = shreg;
    dout_nxt       = dout;
    perr_nxt       = perr;
    armed_nxt      = armed;
    valid_nxt      = 1'b0;
    frame_err_nxt  = 1'b0;
    parity_err_nxt = 1'b0;

    if (tick && (state != IDLE)) phase_nxt = phase + 2'd1;

    unique case (state)
      IDLE: begin
        if (tick) begin
          // armed blocks re-detecting a held-low break after a framing error
          if (!rs && armed) begin
            state_nxt = START;
            phase_nxt = 2'd0;
          end
          if (rs) armed_nxt = 1'b1;
        end
      end
      START: begin
        if (sample) begin
          if (rs) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_idx_nxt = 3'd0;
            perr_nxt    = 1'b0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shreg_nxt[bit_idx] = rs;
          bit_idx_nxt        = bit_idx + 3'd1;
          if (bit_idx == LAST_IDX) begin
            if (PAR_EN) state_nxt = PARITY;
            else        state_nxt = STOP;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          perr_nxt  = rs ^ (^shreg) ^ PAR_ODD;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          dout_nxt  = shreg;
          state_nxt = IDLE;
          if (rs) begin
            valid_nxt      = 1'b1;
            parity_err_nxt = perr;
          end else begin
            frame_err_nxt = 1'b1;
            armed_nxt     = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_os4.sv
// Directed bench for uart_rx_os4: an 8N1 instance and an 8E1 instance on shared clk/tick/reset.
module tb_uart_rx_os4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       rxd, rxd_p;
  logic [7:0] dout, dout_p;
  logic       valid, frame_err, parity_err, busy;
  logic       valid_p, frame_err_p, parity_err_p, busy_p;

  int checks = 0;
  int errors = 0;
  int tcnt   = 0;

  int         vcnt = 0, fcnt = 0, stray = 0, busy_at_v = 0;
  logic [7:0] vq[$];
  int         vcnt_p = 0, pe_last = 0;

  int v0, f0, q0;

  uart_rx_os4 #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rxd(rxd),
    .dout(dout), .valid(valid), .frame_err(frame_err),
    .parity_err(parity_err), .busy(busy)
  );

  uart_rx_os4 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dutp (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rxd(rxd_p),
    .dout(dout_p), .valid(valid_p), .frame_err(frame_err_p),
    .parity_err(parity_err_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tcnt == 0);
      tcnt = (tcnt + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (valid) begin
      vcnt++;
      vq.push_back(dout);
      busy_at_v = int'(busy);
    end
    if (frame_err) fcnt++;
    if (parity_err && !valid) stray++;
    if (valid_p) begin
      vcnt_p++;
      pe_last = int'(parity_err_p);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_bit(input bit sel, input logic v);
    if (sel) rxd_p = v;
    else     rxd   = v;
    wait_ticks(4);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input bit par,
                            input logic pbit, input logic stop);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, data[i]);
    if (par) send_bit(sel, pbit);
    send_bit(sel, stop);
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    rxd_p = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'h00);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    rst_n = 1'b1;

    // 1: idle line
    wait_ticks(100);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid_cnt", vcnt, 0);
    chk("idle_dout", {24'd0, dout}, 32'h00);
    chk("idle_ferr_cnt", fcnt, 0);

    // 2: 0xA5 8N1
    v0 = vcnt; f0 = fcnt; q0 = vq.size();
    wait_ticks(1);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    chk("a5_valid_cnt", vcnt - v0, 1);
    chk("a5_dout", {24'd0, dout}, 32'hA5);
    chk("a5_q", (vq.size() > q0) ? {24'd0, vq[q0]} : 32'hDEAD, 32'hA5);
    chk("a5_ferr", fcnt - f0, 0);
    chk("a5_busy_at_v", busy_at_v, 0);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);

    // 3: one-tick glitch is a false start
    v0 = vcnt; f0 = fcnt;
    rxd = 1'b0;
    wait_ticks(1);
    chk("glitch_detect", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    wait_ticks(2);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    wait_ticks(40);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_ferr", fcnt - f0, 0);
    chk("glitch_dout", {24'd0, dout}, 32'hA5);

    // 4: framing error then held break
    v0 = vcnt; f0 = fcnt;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    wait_ticks(36);
    chk("brk_ferr_cnt", fcnt - f0, 1);
    chk("brk_valid_cnt", vcnt - v0, 0);
    chk("brk_dout", {24'd0, dout}, 32'h3C);
    chk("brk_busy", {31'd0, busy}, 32'd0);
    chk("brk_stray_pe", stray, 0);
    rxd = 1'b1;
    wait_ticks(4);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    chk("rearm_valid", vcnt - v0, 1);
    chk("rearm_dout", {24'd0, dout}, 32'h5A);

    // 5: even parity instance
    v0 = vcnt_p;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    chk("par_bad_valid", vcnt_p - v0, 1);
    chk("par_bad_pe", pe_last, 1);
    chk("par_dout", {24'd0, dout_p}, 32'h07);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    chk("par_good_valid", vcnt_p - v0, 2);
    chk("par_good_pe", pe_last, 0);
    chk("par_ferr", {31'd0, frame_err_p}, 32'd0);

    // 6: reset mid-DATA, then a clean frame
    v0 = vcnt;
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    rst_n = 1'b0;
    rxd   = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_dout", {24'd0, dout}, 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(8);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", vcnt - v0, 1);
    chk("mid_rst_81", {24'd0, dout}, 32'h81);

    // back-to-back frames
    v0 = vcnt; q0 = vq.size();
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_ticks(4);
    chk("b2b_cnt", vcnt - v0, 2);
    chk("b2b_first", (vq.size() > q0) ? {24'd0, vq[q0]} : 32'hDEAD, 32'h00);
    chk("b2b_second", (vq.size() > q0 + 1) ? {24'd0, vq[q0+1]} : 32'hDEAD, 32'hFF);
    chk("final_stray_pe", stray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
